ads1675_seq_ctrl: RTL and testbench
===================================

Name: ads1675_seq_ctrl

Overview:
Power-up, lock and rate-configuration sequencer for one ADS1675 ADC channel. It drives the ADC's static config and control pins (pown, start, cs_n, dr[2:0], fpath, ll_cfg). It discards the lock DRDY and toggles START before capture, then gates the downstream LVDS receiver through cap_en. It also watches for DRDY loss and retries or faults. It sits beside the sclk-domain receiver and runs entirely in the aclk system domain.

Parameters:
PWR_CYC, 1000, aclk cycles from pown high to start high (power-up settle)
START_LOW_CYC, 8, aclk cycles start is held low for the toggle and the power-down pulse width
TIMEOUT_CYC, 4096, aclk cycles without a DRDY rise before a timeout is declared (LOCK_WAIT and RUN)
DISCARD_N, 1, DRDY rises ignored in LOCK_WAIT (lock pulse)
MAX_RETRY, 3, consecutive timeouts allowed before FAULT
DR_DEFAULT, 3'b100, reset value of {dr2,dr1,dr0}
FPATH_DEFAULT, 1'b0, reset value of fpath
LL_DEFAULT, 1'b1, reset value of ll_cfg

Ports:
aclk  in  1  system clock; all logic is on its rising edge
areset  in  1  asynchronous, active-high reset
enable  in  1  level; 1 requests the converter running, 0 forces OFF
cfg_req  in  1  configuration request; held with cfg_* until cfg_ack
cfg_dr  in  3  requested {dr2,dr1,dr0}
cfg_fpath  in  1  requested fpath
cfg_ll  in  1  requested ll_cfg
cfg_ack  out  1  one-cycle pulse: cfg_* has been latched onto the pins
drdy  in  1  ADC DRDY (single-ended after IBUFDS), asynchronous to aclk
pown  out  1  ADC power-on (1 = powered)
start  out  1  ADC START
cs_n  out  1  ADC chip select, active low
dr  out  3  {dr2,dr1,dr0} data-rate select
fpath  out  1  filter path select
ll_cfg  out  1  low-latency configuration
cap_en  out  1  receiver capture enable
fault  out  1  sticky fault flag
state  out  3  encoded FSM state, for debug

Behaviour:
- drdy passes through a 2-flop synchronizer. drdy_rise = s1 & ~s2, registered once more, so detection latency is 3 aclk cycles after the async edge.
- All outputs are registered.
- Reset state: OFF. Outputs: pown=0, start=0, cs_n=1, cap_en=0, cfg_ack=0, fault=0, dr=DR_DEFAULT, fpath=FPATH_DEFAULT, ll_cfg=LL_DEFAULT. Internal: retry=0, counters=0.
- State encoding: OFF=0, PWR_DOWN=1, PWR_WAIT=2, LOCK_WAIT=3, START_LOW=4, RUN=5, RECONFIG=6, FAULT=7.
- OFF: pown=0, start=0, cs_n=1.
  - cfg_req latches cfg_* onto the pins and pulses cfg_ack on the next cycle; the state stays OFF.
  - enable=1 -> PWR_WAIT; cfg_req in the same cycle is serviced first (latch and ack), then the transition.
- PWR_DOWN: pown=0, start=0, cs_n=1 for START_LOW_CYC cycles, then PWR_WAIT.
- PWR_WAIT: pown=1, start=0, cs_n=0 for PWR_CYC cycles, then LOCK_WAIT.
- LOCK_WAIT: start=1, cap_en=0.
  - Counts DRDY rises; when the count reaches DISCARD_N -> START_LOW.
  - The timeout counter resets on each rise.
- START_LOW: start=0 for START_LOW_CYC cycles, then RUN.
- RUN: start=1, cap_en=1 from the entry cycle.
  - The timeout counter resets on each DRDY rise.
  - The first rise in RUN clears retry.
- RECONFIG (entered from RUN or LOCK_WAIT on cfg_req):
  - Entry cycle: start=0, cap_en=0, cfg_* latched onto the pins, cfg_ack pulses.
  - Holds START_LOW_CYC cycles, then LOCK_WAIT (relock and discard again).
- cfg_req is ignored in PWR_DOWN, PWR_WAIT, START_LOW and FAULT; the requester keeps holding it.
- Timeout (counter reaches TIMEOUT_CYC in LOCK_WAIT or RUN): cap_en=0, retry+1.
  - If the new retry value is < MAX_RETRY -> PWR_DOWN.
  - Otherwise -> FAULT.
- FAULT: pown=0, start=0, cs_n=1, cap_en=0, fault=1. The block stays there until enable=0.
- Priority per cycle: enable=0 > timeout > drdy_rise > cfg_req.
  - A DRDY rise in the same cycle the counter would expire cancels the timeout.
- enable=0 in any state -> OFF on the next edge.
  - pown, start, cap_en, fault and retry are cleared; cs_n goes to 1.
  - dr, fpath and ll_cfg keep their latched values.
- areset asserted mid-operation returns to the reset values asynchronously, including dr=DR_DEFAULT.
- Counters saturate; they are sized with $clog2 of the largest parameter + 1.

Test Plan:
All scenarios use PWR_CYC=16, START_LOW_CYC=4, TIMEOUT_CYC=64, MAX_RETRY=2, with DRDY pulses every 40 aclk cycles.
- Power-up: release areset, enable=1 -> pown=1 next cycle; start=1 after 16 cycles; the first DRDY is discarded; start=0 for exactly 4 cycles; then start=1 and cap_en=1.
- Reconfig in RUN: cfg_req with cfg_dr=3'b101 -> same-edge cfg_ack pulse of 1 cycle; dr=101; cap_en=0, start=0 for 4 cycles; relock; cap_en=1 again after the next DRDY plus 4 cycles.
- DRDY loss in RUN: stop DRDY -> after 64 cycles cap_en=0 and pown=0 for 4 cycles, then re-power. DRDY still absent -> second timeout -> state=7, fault=1, pown=0. enable=0 -> state=0, fault=0.
- Simultaneous events: DRDY rise on the exact cycle the timeout expires -> no timeout. cfg_req together with a timeout -> timeout is taken and cfg_ack stays 0.
- Config while OFF: cfg_req with cfg_dr=3'b001, cfg_ll=0 -> cfg_ack the next cycle, pins updated, pown stays 0. Then enable=1 -> the power-up sequence keeps dr=001.
- areset pulse during RECONFIG -> all outputs at reset values immediately with dr=3'b100; cfg_ack is not re-pulsed.

Source files
------------

// File: rtl/ads1675_seq_ctrl_if.sv
// Configuration handshake between the rate-select requester and the ADS1675 sequencer.
// The requester holds cfg_req with cfg_* stable until it sees the one-cycle cfg_ack.
interface ads1675_seq_ctrl_if;
  logic       cfg_req;
  logic [2:0] cfg_dr;
  logic       cfg_fpath;
  logic       cfg_ll;
  logic       cfg_ack;

  modport master (output cfg_req, cfg_dr, cfg_fpath, cfg_ll, input cfg_ack);
  modport slave  (input cfg_req, cfg_dr, cfg_fpath, cfg_ll, output cfg_ack);
endinterface

// File: rtl/ads1675_seq_ctrl.sv
// Power-up, lock, rate-configuration and DRDY-loss recovery sequencer for one ADS1675 channel.
// Runs entirely in the aclk domain; drdy is synchronized here.
module ads1675_seq_ctrl #(
  parameter int         PWR_CYC       = 1000,
  parameter int         START_LOW_CYC = 8,
  parameter int         TIMEOUT_CYC   = 4096,
  parameter int         DISCARD_N     = 1,
  parameter int         MAX_RETRY     = 3,
  parameter logic [2:0] DR_DEFAULT    = 3'b100,
  parameter logic       FPATH_DEFAULT = 1'b0,
  parameter logic       LL_DEFAULT    = 1'b1
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 enable,
  ads1675_seq_ctrl_if.slave    cfg,
  input  logic                 drdy,
  output logic                 pown,
  output logic                 start,
  output logic                 cs_n,
  output logic [2:0]           dr,
  output logic                 fpath,
  output logic                 ll_cfg,
  output logic                 cap_en,
  output logic                 fault,
  output logic [2:0]           state
);

  localparam int CNT_MAX = (PWR_CYC > TIMEOUT_CYC)
                         ? ((PWR_CYC > START_LOW_CYC) ? PWR_CYC : START_LOW_CYC)
                         : ((TIMEOUT_CYC > START_LOW_CYC) ? TIMEOUT_CYC : START_LOW_CYC);
  localparam int CNT_W  = $clog2(CNT_MAX) + 1;
  localparam int RISE_W = $clog2(DISCARD_N) + 1;
  localparam int RET_W  = $clog2(MAX_RETRY) + 1;

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    PWR_DOWN  = 3'd1,
    PWR_WAIT  = 3'd2,
    LOCK_WAIT = 3'd3,
    START_LOW = 3'd4,
    RUN       = 3'd5,
    RECONFIG  = 3'd6,
    FAULT     = 3'd7
  } state_t;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [RISE_W-1:0] sat_rise(input logic [RISE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [RET_W-1:0] sat_ret(input logic [RET_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t              st;
  logic [CNT_W-1:0]    cnt;
  logic [RISE_W-1:0]   rcnt;
  logic [RET_W-1:0]    retry;
  logic                drdy_p0, drdy_p1, rise_p2;
  logic                tmo, cfg_take, slow_done, pwr_done;
  logic [RISE_W-1:0]   rise_nxt;
  logic [RET_W-1:0]    ret_nxt;

  // Stage p0/p1: two-flop synchronizer; p2: registered rising-edge detect
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      drdy_p0 <= 1'b0;
      drdy_p1 <= 1'b0;
      rise_p2 <= 1'b0;
    end else begin
      drdy_p0 <= drdy;
      drdy_p1 <= drdy_p0;
      rise_p2 <= drdy_p0 & ~drdy_p1;
    end
  end

  // A rise on the expiry cycle wins over the timeout; a request already acked is not re-served
  assign tmo       = (cnt == CNT_W'(TIMEOUT_CYC - 1)) && !rise_p2;
  assign cfg_take  = cfg.cfg_req && !cfg.cfg_ack;
  assign slow_done = (cnt == CNT_W'(START_LOW_CYC - 1));
  assign pwr_done  = (cnt == CNT_W'(PWR_CYC - 1));
  assign rise_nxt  = sat_rise(rcnt);
  assign ret_nxt   = sat_ret(retry);
  assign state     = st;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      st          <= OFF;
      pown        <= 1'b0;
      start       <= 1'b0;
      cs_n        <= 1'b1;
      cap_en      <= 1'b0;
      fault       <= 1'b0;
      dr          <= DR_DEFAULT;
      fpath       <= FPATH_DEFAULT;
      ll_cfg      <= LL_DEFAULT;
      cfg.cfg_ack <= 1'b0;
      cnt         <= '0;
      rcnt        <= '0;
      retry       <= '0;
    end else begin
      cfg.cfg_ack <= 1'b0;
      if (!enable && st != OFF) begin
        st     <= OFF;
        pown   <= 1'b0;
        start  <= 1'b0;
        cs_n   <= 1'b1;
        cap_en <= 1'b0;
        fault  <= 1'b0;
        retry  <= '0;
        cnt    <= '0;
        rcnt   <= '0;
      end else begin
        case (st)
          OFF: begin
            if (cfg_take) begin
              dr          <= cfg.cfg_dr;
              fpath       <= cfg.cfg_fpath;
              ll_cfg      <= cfg.cfg_ll;
              cfg.cfg_ack <= 1'b1;
            end
            if (enable) begin
              st   <= PWR_WAIT;
              pown <= 1'b1;
              cs_n <= 1'b0;
              cnt  <= '0;
            end
          end
          PWR_DOWN: begin
            if (slow_done) begin
              st   <= PWR_WAIT;
              pown <= 1'b1;
              cs_n <= 1'b0;
              cnt  <= '0;
            end else cnt <= sat_cnt(cnt);
          end
          PWR_WAIT: begin
            if (pwr_done) begin
              st    <= LOCK_WAIT;
              start <= 1'b1;
              cnt   <= '0;
              rcnt  <= '0;
            end else cnt <= sat_cnt(cnt);
          end
          LOCK_WAIT, RUN: begin
            if (tmo) begin
              // Lost DRDY: power-cycle the ADC, or give up once retries are spent
              pown   <= 1'b0;
              start  <= 1'b0;
              cs_n   <= 1'b1;
              cap_en <= 1'b0;
              retry  <= ret_nxt;
              cnt    <= '0;
              if (ret_nxt < RET_W'(MAX_RETRY)) st <= PWR_DOWN;
              else begin
                st    <= FAULT;
                fault <= 1'b1;
              end
            end else if (rise_p2) begin
              cnt <= '0;
              if (st == LOCK_WAIT) begin
                rcnt <= rise_nxt;
                if (rise_nxt >= RISE_W'(DISCARD_N)) begin
                  st    <= START_LOW;
                  start <= 1'b0;
                end
              end else retry <= '0;
            end else if (cfg_take) begin
              st          <= RECONFIG;
              start       <= 1'b0;
              cap_en      <= 1'b0;
              cnt         <= '0;
              dr          <= cfg.cfg_dr;
              fpath       <= cfg.cfg_fpath;
              ll_cfg      <= cfg.cfg_ll;
              cfg.cfg_ack <= 1'b1;
            end else cnt <= sat_cnt(cnt);
          end
          START_LOW: begin
            if (slow_done) begin
              st     <= RUN;
              start  <= 1'b1;
              cap_en <= 1'b1;
              cnt    <= '0;
            end else cnt <= sat_cnt(cnt);
          end
          RECONFIG: begin
            if (slow_done) begin
              st    <= LOCK_WAIT;
              start <= 1'b1;
              cnt   <= '0;
              rcnt  <= '0;
            end else cnt <= sat_cnt(cnt);
          end
          FAULT: ;
          default: st <= OFF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ads1675_seq_ctrl.sv
// Bench for ads1675_seq_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a phase/deadline reference model of the sequencer.
module tb_ads1675_seq_ctrl;
  localparam int PWR = 16;
  localparam int SL  = 4;
  localparam int TMO = 64;
  localparam int MR  = 2;
  localparam int DN  = 1;

  localparam int S_OFF = 0, S_PDN = 1, S_PWAIT = 2, S_LOCK = 3;
  localparam int S_SLOW = 4, S_RUN = 5, S_RCFG = 6, S_FAULT = 7;

  localparam logic [14:0] RST_VEC = {3'd0, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  logic       aclk = 1'b0;
  logic       areset;
  logic       enable;
  logic       drdy;
  logic       gen_hi = 1'b0;
  logic       manual_hi = 1'b0;
  logic       gen_on = 1'b0;
  logic       gen_rand = 1'b0;
  logic       pulse_ok = 1'b1;
  int         gcnt = 0;
  logic       pown, start, cs_n, fpath, ll_cfg, cap_en, fault;
  logic [2:0] dr, state;
  logic [14:0] obs;
  int         n_chk = 0;
  int         n_err = 0;

  ads1675_seq_ctrl_if cfg_if ();

  ads1675_seq_ctrl #(
    .PWR_CYC(PWR), .START_LOW_CYC(SL), .TIMEOUT_CYC(TMO), .DISCARD_N(DN), .MAX_RETRY(MR),
    .DR_DEFAULT(3'b100), .FPATH_DEFAULT(1'b0), .LL_DEFAULT(1'b1)
  ) dut (
    .aclk(aclk), .areset(areset), .enable(enable), .cfg(cfg_if), .drdy(drdy),
    .pown(pown), .start(start), .cs_n(cs_n), .dr(dr), .fpath(fpath), .ll_cfg(ll_cfg),
    .cap_en(cap_en), .fault(fault), .state(state)
  );

  always #5 aclk = ~aclk;

  assign drdy = gen_hi | manual_hi;
  assign obs  = {state, pown, start, cs_n, dr, fpath, ll_cfg, cap_en, fault, cfg_if.cfg_ack};

  // DRDY source: a 2-cycle pulse every 40 cycles, optionally skipping random periods
  always @(negedge aclk) begin
    if (!gen_on) begin
      gcnt     <= 0;
      gen_hi   <= 1'b0;
      pulse_ok <= 1'b1;
    end else begin
      gcnt   <= (gcnt == 39) ? 0 : gcnt + 1;
      gen_hi <= pulse_ok && (gcnt == 39 || gcnt == 0);
      if (gcnt == 20) pulse_ok <= !gen_rand || ($urandom_range(3) != 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Reference model: phase timers and time-since-last-DRDY, outputs derived per phase
  typedef struct {
    int         st;
    int         in_ph;
    int         quiet;
    int         seen;
    int         retry;
    logic [3:0] h;
    logic [2:0] dr;
    logic       fp;
    logic       ll;
    logic       ack;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.st = S_OFF; r.in_ph = 0; r.quiet = 0; r.seen = 0; r.retry = 0;
    r.h = 4'b0; r.dr = 3'b100; r.fp = 1'b0; r.ll = 1'b1; r.ack = 1'b0;
    return r;
  endfunction

  function automatic mdl_t enter(mdl_t x, int s);
    x.st = s; x.in_ph = 0; x.quiet = 0; x.seen = 0;
    return x;
  endfunction

  function automatic mdl_t mdl_step(mdl_t c, logic en, logic req, logic [2:0] cdr,
                                    logic cfp, logic cll, logic din);
    mdl_t n = c;
    logic rise = c.h[1] & ~c.h[2];
    logic svc = 1'b0;
    n.h = {c.h[2:0], din};
    n.ack = 1'b0;
    n.in_ph = c.in_ph + 1;
    n.quiet = c.quiet + 1;
    if (!en && c.st != S_OFF) begin
      n = enter(n, S_OFF);
      n.retry = 0;
    end else begin
      case (c.st)
        S_OFF: begin
          svc = req;
          if (en) n = enter(n, S_PWAIT);
        end
        S_PDN:   if (n.in_ph == SL)  n = enter(n, S_PWAIT);
        S_PWAIT: if (n.in_ph == PWR) n = enter(n, S_LOCK);
        S_SLOW:  if (n.in_ph == SL)  n = enter(n, S_RUN);
        S_RCFG:  if (n.in_ph == SL)  n = enter(n, S_LOCK);
        S_LOCK, S_RUN: begin
          if (!rise && n.quiet >= TMO) begin
            n.retry = c.retry + 1;
            n = enter(n, (n.retry < MR) ? S_PDN : S_FAULT);
          end else if (rise) begin
            n.quiet = 0;
            if (c.st == S_LOCK) begin
              n.seen = c.seen + 1;
              if (n.seen >= DN) n = enter(n, S_SLOW);
            end else n.retry = 0;
          end else if (req) begin
            svc = 1'b1;
            n = enter(n, S_RCFG);
          end
        end
        default: ;
      endcase
    end
    if (svc) begin
      n.dr = cdr; n.fp = cfp; n.ll = cll; n.ack = 1'b1;
    end
    return n;
  endfunction

  function automatic logic [14:0] mdl_out(mdl_t x);
    logic pw = (x.st >= S_PWAIT) && (x.st <= S_RCFG);
    logic st_hi = (x.st == S_LOCK) || (x.st == S_RUN);
    return {3'(x.st), pw, st_hi, !pw, x.dr, x.fp, x.ll, x.st == S_RUN, x.st == S_FAULT, x.ack};
  endfunction

  always @(posedge aclk or posedge areset) begin
    if (areset) m <= mdl_reset();
    else m <= mdl_step(m, enable, cfg_if.cfg_req, cfg_if.cfg_dr, cfg_if.cfg_fpath,
                       cfg_if.cfg_ll, drdy);
  end

  always @(negedge aclk) chk("cycle", 32'(obs), 32'(mdl_out(m)));

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    areset = 1'b1; enable = 1'b0;
    cfg_if.cfg_req = 1'b0; cfg_if.cfg_dr = 3'b0; cfg_if.cfg_fpath = 1'b0; cfg_if.cfg_ll = 1'b0;
    repeat (3) @(negedge aclk);
    chk("reset_vals", 32'(obs), 32'(RST_VEC));
    areset = 1'b0;
    @(negedge aclk);

    // Config while OFF
    cfg_if.cfg_req = 1'b1; cfg_if.cfg_dr = 3'b001; cfg_if.cfg_ll = 1'b0; cfg_if.cfg_fpath = 1'b0;
    @(negedge aclk);
    chk("off_ack", 32'(cfg_if.cfg_ack), 32'd1);
    chk("off_dr", 32'(dr), 32'd1);
    chk("off_ll", 32'(ll_cfg), 32'd0);
    chk("off_pown", 32'(pown), 32'd0);
    cfg_if.cfg_req = 1'b0;
    @(negedge aclk);
    chk("off_ack_pulse", 32'(cfg_if.cfg_ack), 32'd0);

    // Power-up
    gen_on = 1'b1; enable = 1'b1;
    @(negedge aclk);
    chk("pwr_pown", 32'(pown), 32'd1);
    chk("pwr_state", 32'(state), 32'd2);
    n = 0; while (!start && n < 100) begin @(negedge aclk); n++; end
    chk("pwr_settle", 32'(n), 32'(PWR));
    n = 0; while (start && n < 200) begin @(negedge aclk); n++; end
    chk("lock_discard", 32'(start), 32'd0);
    n = 0; while (!start && n < 100) begin @(negedge aclk); n++; end
    chk("start_low_len", 32'(n), 32'(SL));
    chk("run_cap", 32'(cap_en), 32'd1);
    chk("run_dr", 32'(dr), 32'd1);

    // Reconfig in RUN
    repeat (3) @(negedge aclk);
    cfg_if.cfg_req = 1'b1; cfg_if.cfg_dr = 3'b101;
    @(negedge aclk);
    chk("rc_ack", 32'(cfg_if.cfg_ack), 32'd1);
    chk("rc_dr", 32'(dr), 32'd5);
    chk("rc_cap", 32'(cap_en), 32'd0);
    chk("rc_start", 32'(start), 32'd0);
    chk("rc_state", 32'(state), 32'd6);
    cfg_if.cfg_req = 1'b0;
    @(negedge aclk);
    chk("rc_ack_pulse", 32'(cfg_if.cfg_ack), 32'd0);
    n = 1; while (!start && n < 100) begin @(negedge aclk); n++; end
    chk("rc_start_low_len", 32'(n), 32'(SL));
    chk("rc_relock_state", 32'(state), 32'd3);
    n = 0; while (!cap_en && n < 200) begin @(negedge aclk); n++; end
    chk("rc_recap", 32'(cap_en), 32'd1);

    // DRDY rise landing exactly on the expiry cycle, then a timeout racing a cfg_req
    gen_on = 1'b0; manual_hi = 1'b1;
    repeat (2) @(negedge aclk);
    manual_hi = 1'b0;
    repeat (62) @(negedge aclk);
    manual_hi = 1'b1;
    repeat (2) @(negedge aclk);
    manual_hi = 1'b0;
    @(negedge aclk);
    chk("sim_no_tmo_state", 32'(state), 32'd5);
    chk("sim_no_tmo_cap", 32'(cap_en), 32'd1);
    repeat (63) @(negedge aclk);
    cfg_if.cfg_req = 1'b1; cfg_if.cfg_dr = 3'b010;
    @(negedge aclk);
    chk("tmo_vs_cfg_state", 32'(state), 32'd1);
    chk("tmo_vs_cfg_ack", 32'(cfg_if.cfg_ack), 32'd0);
    chk("tmo_vs_cfg_pown", 32'(pown), 32'd0);
    n = 0; while (!cfg_if.cfg_ack && n < 200) begin @(negedge aclk); n++; end
    chk("late_ack", 32'(cfg_if.cfg_ack), 32'd1);
    cfg_if.cfg_req = 1'b0; gen_on = 1'b1;
    n = 0; while (!cap_en && n < 400) begin @(negedge aclk); n++; end
    chk("rerun_cap", 32'(cap_en), 32'd1);

    // DRDY loss in RUN: one retry, then FAULT
    repeat (100) @(negedge aclk);
    gen_on = 1'b0;
    n = 0; while (cap_en && n < 200) begin @(negedge aclk); n++; end
    chk("loss_cap", 32'(cap_en), 32'd0);
    chk("loss_pown", 32'(pown), 32'd0);
    chk("loss_state", 32'(state), 32'd1);
    n = 0; while (!pown && n < 100) begin @(negedge aclk); n++; end
    chk("loss_pdn_len", 32'(n), 32'(SL));
    n = 0; while (state != 3'd7 && n < 300) begin @(negedge aclk); n++; end
    chk("fault_state", 32'(state), 32'd7);
    chk("fault_flag", 32'(fault), 32'd1);
    chk("fault_pown", 32'(pown), 32'd0);
    repeat (3) @(negedge aclk);
    chk("fault_sticky", 32'(fault), 32'd1);
    enable = 1'b0;
    @(negedge aclk);
    chk("off_state", 32'(state), 32'd0);
    chk("off_fault", 32'(fault), 32'd0);
    chk("off_dr_kept", 32'(dr), 32'd2);

    // areset during RECONFIG
    gen_on = 1'b1; enable = 1'b1;
    n = 0; while (!cap_en && n < 400) begin @(negedge aclk); n++; end
    chk("ar_run", 32'(cap_en), 32'd1);
    repeat (2) @(negedge aclk);
    cfg_if.cfg_req = 1'b1; cfg_if.cfg_dr = 3'b011;
    @(negedge aclk);
    chk("ar_reconfig", 32'(state), 32'd6);
    cfg_if.cfg_req = 1'b0;
    #2 areset = 1'b1;
    #1 chk("ar_vals", 32'(obs), 32'(RST_VEC));
    enable = 1'b0;
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    chk("ar_no_reack", 32'(cfg_if.cfg_ack), 32'd0);

    // Randomized traffic against the model
    enable = 1'b1; gen_rand = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      @(negedge aclk);
      if (cfg_if.cfg_req && cfg_if.cfg_ack) cfg_if.cfg_req = 1'b0;
      else if (!cfg_if.cfg_req && $urandom_range(59) == 0) begin
        cfg_if.cfg_req   = 1'b1;
        cfg_if.cfg_dr    = 3'($urandom_range(7));
        cfg_if.cfg_fpath = 1'($urandom_range(1));
        cfg_if.cfg_ll    = 1'($urandom_range(1));
      end
      if (enable && $urandom_range(999) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(15) == 0) enable = 1'b1;
    end

    repeat (2) @(negedge aclk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
